// File: rtl/ifu_fd.sv
// Fetch/decode front end: registered fetch PC and F->D pipeline register with
// D-stage next-PC selection (branch, j/jal, jr) and a one-instruction delay slot.
module ifu_fd #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        D_flush_ds,
  input  logic [1:0]  D_npc_op,
  input  logic        D_b_result,
  input  logic [31:0] D_rs_val,
  input  logic [31:0] F_instr,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic [31:0] D_pc8
);

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  logic [31:0] seq_pc;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] next_pc;

  assign seq_pc = F_pc + 32'd4;
  assign br_tgt = D_pc + 32'd4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
  assign j_tgt  = {D_pc[31:28], D_instr[25:0], 2'b00};
  assign D_pc8  = D_pc + 32'd8;

  // Redirects come only from a live instruction in D; a bubble never steers fetch.
  always_comb begin
    next_pc = seq_pc;
    if (D_valid) begin
      case (D_npc_op)
        NPC_BR:  if (D_b_result) next_pc = br_tgt;
        NPC_J:   next_pc = j_tgt;
        NPC_JR:  next_pc = D_rs_val;
        NPC_SEQ: next_pc = seq_pc;
        default: next_pc = seq_pc;
      endcase
    end
  end

  // stall freezes everything, so a held control instruction is simply re-evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      F_pc    <= PC_RESET;
      D_pc    <= PC_RESET;
      D_instr <= '0;
      D_valid <= 1'b0;
    end else if (!stall) begin
      F_pc <= next_pc;
      D_pc <= F_pc;
      if (D_flush_ds) begin
        D_instr <= '0;
        D_valid <= 1'b0;
      end else begin
        D_instr <= F_instr;
        D_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fd.sv
// Directed bench for ifu_fd: a behavioural front-end model checked every cycle,
// plus literal expectations for the key redirect/stall/flush/reset scenarios.
module tb_ifu_fd;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        D_flush_ds = 1'b0;
  logic [1:0]  D_npc_op = 2'b00;
  logic        D_b_result = 1'b0;
  logic [31:0] D_rs_val = '0;
  logic [31:0] F_instr = '0;
  logic [31:0] F_pc, D_pc, D_instr, D_pc8;
  logic        D_valid;

  int checks = 0;
  int failures = 0;

  ifu_fd #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .D_flush_ds(D_flush_ds),
    .D_npc_op(D_npc_op), .D_b_result(D_b_result), .D_rs_val(D_rs_val),
    .F_instr(F_instr), .F_pc(F_pc), .D_pc(D_pc), .D_instr(D_instr),
    .D_valid(D_valid), .D_pc8(D_pc8)
  );

  always #5 clk = ~clk;

  // Model state: what fetch and decode hold, derived from the rules in prose form.
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dv;

  function automatic logic [31:0] model_next(input logic [31:0] fpc, input logic [31:0] dpc,
                                             input logic [31:0] dins, input logic dv,
                                             input logic [1:0] op, input logic bres,
                                             input logic [31:0] rs);
    int off;
    off = int'($signed(dins[15:0]));
    if (dv && op == 2'd1 && bres) return dpc + 32'(4 + off * 4);
    if (dv && op == 2'd2) return (dpc & 32'hF000_0000) | ((dins & 32'h03FF_FFFF) * 32'd4);
    if (dv && op == 2'd3) return rs;
    return fpc + 32'd4;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fpc <= 32'h3000; m_dpc <= 32'h3000; m_dinstr <= '0; m_dv <= 1'b0;
    end else if (!stall) begin
      m_fpc    <= model_next(m_fpc, m_dpc, m_dinstr, m_dv, D_npc_op, D_b_result, D_rs_val);
      m_dpc    <= m_fpc;
      m_dinstr <= D_flush_ds ? 32'h0 : F_instr;
      m_dv     <= !D_flush_ds;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_F_pc", F_pc, m_fpc);
    chk("cyc_D_pc", D_pc, m_dpc);
    chk("cyc_D_instr", D_instr, m_dinstr);
    chk("cyc_D_valid", {31'b0, D_valid}, {31'b0, m_dv});
    chk("cyc_D_pc8", D_pc8, m_dpc + 32'd8);
  end

  task automatic drive(input logic [1:0] op, input logic b, input logic [31:0] rs,
                       input logic [31:0] ins, input logic st, input logic fl);
    D_npc_op = op; D_b_result = b; D_rs_val = rs; F_instr = ins; stall = st; D_flush_ds = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_F_pc", F_pc, 32'h3000);
    chk("rst_D_pc", D_pc, 32'h3000);
    chk("rst_D_instr", D_instr, 32'h0);
    chk("rst_D_valid", {31'b0, D_valid}, 32'h0);
    chk("rst_D_pc8", D_pc8, 32'h3008);
    drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Redirect op with D_valid=0 must be ignored; beq enters D.
    drive(2'b10, 1'b0, 32'h0, 32'h1000_0003, 1'b0, 1'b0);
    tick();
    chk("first_fetch", F_pc, 32'h3004);
    chk("first_dpc", D_pc, 32'h3000);
    // Taken beq: target 0x3004 + 3*4.
    drive(2'b01, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("beq_taken_fpc", F_pc, 32'h3010);
    chk("beq_taken_dpc", D_pc, 32'h3004);
    chk("beq_taken_dv", {31'b0, D_valid}, 32'h1);

    // Not-taken branch-likely nullifies the delay slot.
    do_reset();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b00, 1'b0, '0, 32'h5000_0004, 1'b0, 1'b0); tick();
    drive(2'b01, 1'b0, '0, 32'h1234_5678, 1'b0, 1'b1); tick();
    chk("bl_fpc", F_pc, 32'h300C);
    chk("bl_dinstr", D_instr, 32'h0);
    chk("bl_dv", {31'b0, D_valid}, 32'h0);
    chk("bl_dpc", D_pc, 32'h3008);

    // j then jr.
    do_reset();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b00, 1'b0, '0, 32'h0800_0C10, 1'b0, 1'b0); tick();
    chk("j_dpc", D_pc, 32'h3008);
    drive(2'b10, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    chk("j_fpc", F_pc, 32'h3040);
    drive(2'b11, 1'b0, 32'h0000_3100, 32'h0, 1'b0, 1'b0); tick();
    chk("jr_fpc", F_pc, 32'h3100);

    // Stall (with flush) over a taken branch holds everything.
    do_reset();
    drive(2'b00, 1'b0, '0, 32'h1000_0003, 1'b0, 1'b0); tick();
    drive(2'b01, 1'b1, '0, 32'hAAAA_5555, 1'b1, 1'b1); tick();
    drive(2'b01, 1'b1, '0, 32'hAAAA_5555, 1'b1, 1'b1); tick();
    chk("stall_fpc", F_pc, 32'h3004);
    chk("stall_dpc", D_pc, 32'h3000);
    chk("stall_dinstr", D_instr, 32'h1000_0003);
    chk("stall_dv", {31'b0, D_valid}, 32'h1);
    drive(2'b01, 1'b1, '0, 32'h0, 1'b0, 1'b0); tick();
    chk("stall_release_fpc", F_pc, 32'h3010);

    // Wrap at the top of the address space, then async reset between edges.
    do_reset();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    drive(2'b11, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0); tick();
    chk("jr_top_fpc", F_pc, 32'hFFFF_FFFC);
    drive(2'b00, 1'b0, '0, 32'h0, 1'b1, 1'b0); tick();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    chk("wrap_fpc", F_pc, 32'h0);
    drive(2'b11, 1'b0, 32'h0000_7000, 32'h0, 1'b1, 1'b1);
    #2;
    do_reset();
    drive(2'b00, 1'b0, '0, 32'h0, 1'b0, 1'b0); tick();
    chk("post_rst_fpc", F_pc, 32'h3004);
    chk("post_rst_dpc", D_pc, 32'h3000);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fd.md
IFU_FD -- requirements
Module: ifu_fd

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: PC_RESET, default 32'h0000_3000, PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 stall  input  1  hazard-unit freeze of the F and D stages.
REQ-006 D_flush_ds  input  1  nullify the delay-slot instruction entering D.
REQ-007 D_npc_op  input  2  next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr.
REQ-008 D_b_result  input  1  branch-taken flag from the D-stage comparator.
REQ-009 D_rs_val  input  32  forwarded rs value (jr target).
REQ-010 F_instr  input  32  instruction memory word at F_pc.
REQ-011 F_pc  output  32  fetch PC, registered.
REQ-012 D_pc  output  32  PC of the instruction in D, registered.
REQ-013 D_instr  output  32  instruction in D, registered.
REQ-014 D_valid  output  1  D holds a real, non-nullified instruction.
REQ-015 D_pc8  output  32  D_pc + 8, link address, combinational.

Function
REQ-016 Branch target SHALL be D_pc + 4 + (sign-extended D_instr[15:0] << 2), modulo 2^32.
REQ-017 Jump target SHALL be {D_pc[31:28], D_instr[25:0], 2'b00}; jr target SHALL be D_rs_val used verbatim.
REQ-018 Next PC SHALL be: op 01 with D_b_result=1 -> branch target; op 10 -> jump target; op 11 -> jr target; otherwise F_pc + 4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
REQ-019 Redirects SHALL be qualified by D_valid; if D_valid=0, next PC is F_pc + 4.
REQ-020 When stall=0, on each rising edge: F_pc <= next PC; D_pc <= F_pc; D_instr <= F_instr; D_valid <= 1.
REQ-021 Delay slot: the instruction in F while a control transfer is in D SHALL always advance into D; redirect latency is one cycle (target fetched the cycle after the branch leaves D).
REQ-022 When stall=0 and D_flush_ds=1: D_instr <= 0, D_valid <= 0, D_pc <= F_pc; F_pc still updates per REQ-018.
REQ-023 When stall=1: F_pc, D_pc, D_instr, D_valid SHALL hold; the redirect is not lost because the control instruction remains in D and is re-evaluated.
REQ-024 stall SHALL take priority over D_flush_ds (simultaneous assertion -> hold, no flush).
REQ-025 No internal state beyond the four registers of REQ-020; no combinational path from F_instr to F_pc.

Reset
REQ-026 reset_n=0 SHALL immediately force F_pc=PC_RESET, D_pc=PC_RESET, D_instr=0, D_valid=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any pending redirect, stall, or flush; first edge after release fetches PC_RESET+4 with D_pc=PC_RESET.
REQ-028 D_pc8 SHALL read PC_RESET+8 during reset.

Verification
REQ-029 Taken beq: D_pc=0x3000, D_instr[15:0]=0x0003, op=01, b_result=1, F_pc=0x3004 -> next edge F_pc=0x3010, D_pc=0x3004, D_valid=1.
REQ-030 Not-taken branch-likely: op=01, b_result=0, D_flush_ds=1, F_pc=0x3008 -> F_pc=0x300C, D_instr=0, D_valid=0, D_pc=0x3008.
REQ-031 j/jr: D_pc=0x3008, D_instr=0x0800_0C10, op=10 -> F_pc=0x3040; then op=11, D_rs_val=0x0000_3100 -> F_pc=0x3100.
REQ-032 Stall over branch: taken branch in D, stall=1 for 2 cycles (flush also 1) -> all registers hold; first unstalled edge -> F_pc=branch target.
REQ-033 Wrap and reset: F_pc=0xFFFF_FFFC, op=00 -> F_pc=0; assert reset_n=0 between edges -> F_pc=0x3000, D_valid=0 without a clock edge.
